// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate-left/right, bounce and binary count with a tick prescaler.
// Optional `LED_INVERT_EN drives the led port active-low (bitwise inverse of the pattern).
module led_pattern_gen #(
    parameter int N_LED    = 4,
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [N_LED-1:0] led,
    output logic             step_pulse
);

    typedef enum logic {DIR_L, DIR_R} dir_e;

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [2:0]       stepc_q, stepc_d;
    logic [N_LED-1:0] led_q, led_d, led_nxt;
    dir_e             dir_q, dir_d, dir_nxt;
    logic [1:0]       mode_q, mode_d;
    logic             pulse_q, pulse_d;
    logic             tick, step, mode_chg;
    logic [3:0]       step_lim;

    assign mode_chg = (mode != mode_q);
    assign tick     = en && (presc_q == CNT_W'(TICK_DIV - 1));
    assign step_lim = (4'd1 << speed) - 4'd1;
    // >= so a live decrease of speed below the current count steps on the next tick
    assign step     = tick && ({1'b0, stepc_q} >= step_lim);

    always_comb begin
        led_nxt = led_q;
        dir_nxt = dir_q;
        case (mode_q)
            2'b00: led_nxt = {led_q[N_LED-2:0], led_q[N_LED-1]};
            2'b01: led_nxt = {led_q[0], led_q[N_LED-1:1]};
            2'b10: begin
                if (dir_q == DIR_L) begin
                    if (led_q[N_LED-1]) begin
                        led_nxt = led_q >> 1;
                        dir_nxt = DIR_R;
                    end else begin
                        led_nxt = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        led_nxt = led_q << 1;
                        dir_nxt = DIR_L;
                    end else begin
                        led_nxt = led_q >> 1;
                    end
                end
            end
            default: led_nxt = led_q + N_LED'(1);
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        stepc_d = stepc_q;
        led_d   = led_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        pulse_d = 1'b0;
        if (mode_chg) begin
            mode_d  = mode;
            led_d   = N_LED'(1);
            dir_d   = DIR_L;
            presc_d = '0;
            stepc_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + CNT_W'(1);
            if (step) begin
                stepc_d = '0;
                led_d   = led_nxt;
                dir_d   = dir_nxt;
                pulse_d = 1'b1;
            end else if (tick) begin
                stepc_d = stepc_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            presc_q <= '0;
            stepc_q <= '0;
            led_q   <= N_LED'(1);
            dir_q   <= DIR_L;
            mode_q  <= 2'b00;
            pulse_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            stepc_q <= stepc_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef LED_INVERT_EN
    assign led = ~led_q;
`else
    assign led = led_q;
`endif
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (N_LED=4, TICK_DIV=4).
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       en = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [1:0] speed = 2'b00;
    logic [3:0] led;
    logic       step_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] led;
        int         cyc;
    } exp_t;
    exp_t sbq[$];

    led_pattern_gen #(.N_LED(4), .TICK_DIV(4), .CNT_W(3)) dut (
        .clk(clk), .res(res), .en(en), .mode(mode), .speed(speed),
        .led(led), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] pin(input logic [3:0] p);
`ifdef LED_INVERT_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at cyc %0d", nm, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] p, input int c);
        exp_t e;
        e.led = pin(p);
        e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // change mode, then check the load edge: pattern 0001, no pulse
    task automatic set_mode(input logic [1:0] m, input logic [1:0] s,
                            output int base);
        mode = m;
        speed = s;
        @(negedge clk);
        base = cyc;
        chk("mode_load_led", int'(led), int'(pin(4'b0001)));
        chk("mode_load_pulse", int'(step_pulse), 0);
    endtask

    always @(negedge clk) begin
        if (step_pulse) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse led=%b at cyc %0d", led, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("step_led", int'(led), int'(e.led));
                chk("step_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int b;
        logic [3:0] cnt;
        logic [3:0] bseq [8];
        bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                 4'b0010, 4'b0001, 4'b0010, 4'b0100};

        repeat (2) @(negedge clk);
        chk("reset_led", int'(led), int'(pin(4'b0001)));
        chk("reset_pulse", int'(step_pulse), 0);

        // rotate-left, speed 0
        res = 1'b1;
        b = cyc;
        push(4'b0010, b + 4);
        push(4'b0100, b + 8);
        push(4'b1000, b + 12);
        push(4'b0001, b + 16);
        wait_to(b + 16);

        // rotate-right, speed 1
        set_mode(2'b01, 2'd1, b);
        push(4'b1000, b + 8);
        push(4'b0100, b + 16);
        wait_to(b + 16);

        // bounce, 8 steps
        set_mode(2'b10, 2'd0, b);
        for (int k = 0; k < 8; k++) push(bseq[k], b + 4 * (k + 1));
        wait_to(b + 32);

        // binary count 17 steps, wrapping 1111 -> 0000
        set_mode(2'b11, 2'd0, b);
        cnt = 4'b0001;
        for (int k = 1; k <= 17; k++) begin
            cnt = cnt + 4'd1;
            push(cnt, b + 4 * k);
        end
        wait_to(b + 70);

        // mid-period switch to rotate-left
        set_mode(2'b00, 2'd0, b);
        push(4'b0010, b + 4);
        wait_to(b + 6);

        // freeze for 10 cycles mid-period
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_led", int'(led), int'(pin(4'b0010)));
            chk("hold_pulse", int'(step_pulse), 0);
        end
        en = 1'b1;
        push(4'b0100, b + 18);
        wait_to(b + 20);

        // bounce into dir=right, then async reset between edges
        set_mode(2'b10, 2'd0, b);
        push(4'b0010, b + 4);
        push(4'b0100, b + 8);
        push(4'b1000, b + 12);
        push(4'b0100, b + 16);
        wait_to(b + 16);
        #2 res = 1'b0;
        #1;
        chk("async_reset_led", int'(led), int'(pin(4'b0001)));
        chk("async_reset_pulse", int'(step_pulse), 0);
        @(negedge clk);
        res = 1'b1;
        // mode_q reset to 00 while mode=10: first edge reloads
        set_mode(2'b10, 2'd0, b);
        push(4'b0010, b + 4);
        push(4'b0100, b + 8);
        wait_to(b + 10);

        chk("queue_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
